// File: rtl/fir_filter.sv
// Unsigned TAPS-tap FIR filter with a two-stage pipeline, round-half-up
// right shift and saturation to DW bits.
//
// Ports:
//   clk        - rising-edge clock for all state
//   reset_n    - asynchronous active-low reset (release synchronous to clk)
//   in_valid   - x carries a new sample this cycle
//   x          - input sample, DW bits unsigned
//   flush      - synchronous clear of delay line and pipeline valid bits
//   coef_we    - coefficient write strobe
//   coef_addr  - coefficient index; tap 0 multiplies the newest sample
//   coef_wdata - coefficient value, CW bits unsigned
//   out_valid  - y holds a new result this cycle (2 cycles after in_valid)
//   y          - filtered, rounded, saturated result
//   sat        - result was clipped, qualified by out_valid
module fir_filter #(
  parameter int unsigned DW    = 8,
  parameter int unsigned CW    = 8,
  parameter int unsigned TAPS  = 4,
  parameter int unsigned SHIFT = 3,
  // One extra code point so that out-of-range indices are expressible
  // even when TAPS is a power of two.
  localparam int unsigned ADDR_W = $clog2(TAPS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DW-1:0]     x,
  input  logic              flush,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [CW-1:0]     coef_wdata,
  output logic              out_valid,
  output logic [DW-1:0]     y,
  output logic              sat
);

  localparam int unsigned PW    = DW + CW;
  localparam int unsigned AW    = DW + CW + $clog2(TAPS);
  localparam int unsigned RND_I = (2 ** SHIFT) / 2;
  localparam logic [AW-1:0] RND = AW'(RND_I);

  logic [DW-1:0] tap_q  [TAPS];
  logic [DW-1:0] tap_d  [TAPS];
  logic [CW-1:0] coef_q [TAPS];
  logic [CW-1:0] coef_d [TAPS];
  logic [PW-1:0] prod_q [TAPS];
  logic [PW-1:0] prod_d [TAPS];
  logic          s1_valid_q, s1_valid_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] y_q, y_d;
  logic          sat_q, sat_d;

  logic [DW-1:0] tap_adv_c [TAPS];
  logic [AW-1:0] sum_c;
  logic [AW-1:0] shifted_c;

  // Delay line, coefficient writes and stage-1 products.
  always_comb begin
    for (int unsigned k = 0; k < TAPS; k++) begin
      tap_adv_c[k] = tap_q[k];
      tap_d[k]     = tap_q[k];
      coef_d[k]    = coef_q[k];
      prod_d[k]    = '0;
    end
    s1_valid_d = 1'b0;

    if (in_valid) begin
      tap_adv_c[0] = x;
      for (int unsigned k = 1; k < TAPS; k++) begin
        tap_adv_c[k] = tap_q[k-1];
      end
    end

    // Products see the newly accepted sample but the pre-write coefficients.
    for (int unsigned k = 0; k < TAPS; k++) begin
      prod_d[k] = PW'(tap_adv_c[k]) * PW'(coef_q[k]);
      tap_d[k]  = flush ? '0 : tap_adv_c[k];
      if (coef_we && (coef_addr == ADDR_W'(k))) begin
        coef_d[k] = coef_wdata;
      end
    end

    s1_valid_d = in_valid & ~flush;
  end

  // Stage 2: sum, round, shift and saturate.
  always_comb begin
    sum_c = RND;
    for (int unsigned k = 0; k < TAPS; k++) begin
      sum_c = sum_c + AW'(prod_q[k]);
    end
    shifted_c = sum_c >> SHIFT;

    y_d         = y_q;
    sat_d       = sat_q;
    out_valid_d = s1_valid_q & ~flush;

    // A flushed stage-1 result is dropped, so it must not disturb y/sat.
    if (s1_valid_q && !flush) begin
      if (|shifted_c[AW-1:DW]) begin
        y_d   = '1;
        sat_d = 1'b1;
      end else begin
        y_d   = shifted_c[DW-1:0];
        sat_d = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        tap_q[k]  <= '0;
        coef_q[k] <= CW'(1);
        prod_q[k] <= '0;
      end
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      sat_q       <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        tap_q[k]  <= tap_d[k];
        coef_q[k] <= coef_d[k];
        prod_q[k] <= prod_d[k];
      end
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign sat       = sat_q;

endmodule
